// File: rtl/floo_test_monitor_pkg.sv
// Shared types and width helpers for the FlooNoC test-node traffic monitors.
package floo_test_monitor_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } monitor_state_e;

    // Bits needed to hold values 0..max_val inclusive (never less than 1).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/floo_sat_updown_cnt.sv
// Saturating up/down counter; a blocked step (underflow or overflow) sets a sticky error.
module floo_sat_updown_cnt
    import floo_test_monitor_pkg::*;
#(
    parameter int unsigned Max = 16,
    parameter int unsigned W   = cnt_w(Max)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         err_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
            err_o <= 1'b0;
        end else if (clr_i) begin
            cnt_o <= '0;
            err_o <= 1'b0;
        end else if (en_i && (inc_i != dec_i)) begin
            if (inc_i) begin
                if (cnt_o == W'(Max)) err_o <= 1'b1;
                else                  cnt_o <= cnt_o + 1'b1;
            end else begin
                if (cnt_o == '0) err_o <= 1'b1;
                else             cnt_o <= cnt_o - 1'b1;
            end
        end
    end

endmodule

// File: rtl/floo_traffic_monitor_mc.sv
// Multi-channel AXI traffic monitor: in-flight tracking, beat/window counters and end-of-sim control.
module floo_traffic_monitor_mc
    import floo_test_monitor_pkg::*;
#(
    parameter int unsigned NumChannels  = 2,
    parameter int unsigned MaxInFlight  = 16,
    parameter int unsigned BeatCntWidth = 32,
    parameter int unsigned WindowCycles = 1024,
    parameter int unsigned DrainCycles  = 64,
    localparam int unsigned InFlightW   = cnt_w(MaxInFlight),
    localparam int unsigned WinW        = cnt_w(WindowCycles)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                en_i,
    input  logic [NumChannels-1:0]              end_of_sim_i,
    input  logic [NumChannels-1:0]              ar_hs_i,
    input  logic [NumChannels-1:0]              aw_hs_i,
    input  logic [NumChannels-1:0]              r_hs_i,
    input  logic [NumChannels-1:0]              w_hs_i,
    input  logic [NumChannels-1:0]              r_last_hs_i,
    input  logic [NumChannels-1:0]              b_hs_i,
    output logic [NumChannels*InFlightW-1:0]    rd_inflight_o,
    output logic [NumChannels*InFlightW-1:0]    wr_inflight_o,
    output logic [NumChannels*BeatCntWidth-1:0] rd_beats_o,
    output logic [NumChannels*BeatCntWidth-1:0] wr_beats_o,
    output logic [NumChannels*WinW-1:0]         win_rd_beats_o,
    output logic [NumChannels*WinW-1:0]         win_wr_beats_o,
    output logic                                win_valid_o,
    output logic [NumChannels-1:0]              err_o,
    output logic [1:0]                          state_o,
    output logic                                done_o
);

    localparam int unsigned QuietW = cnt_w(DrainCycles);

    monitor_state_e    state_q, state_d;
    logic [QuietW-1:0] quiet_q, quiet_d;
    logic [WinW-1:0]   win_cnt_q;
    logic              win_valid_q;

    logic [NumChannels-1:0] rd_nz, wr_nz, rd_err, wr_err;
    logic active, clr, all_idle, wrap;

    // Counting only happens while enabled in RUN/DRAIN; IDLE or a dropped enable wipes state.
    assign active   = en_i && ((state_q == StRun) || (state_q == StDrain));
    assign clr      = !en_i || (state_q == StIdle);
    assign all_idle = ~|(rd_nz | wr_nz);
    assign wrap     = active && (win_cnt_q == WinW'(WindowCycles - 1));

    always_comb begin
        state_d = state_q;
        quiet_d = '0;
        case (state_q)
            StIdle:  if (en_i) state_d = StRun;
            StRun:   if (&end_of_sim_i) state_d = StDrain;
            StDrain: begin
                if (all_idle) begin
                    if (quiet_q == QuietW'(DrainCycles - 1)) state_d = StDone;
                    else                                     quiet_d = quiet_q + 1'b1;
                end
            end
            default: state_d = StDone;
        endcase
        if (!en_i) begin
            state_d = StIdle;
            quiet_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            quiet_q <= '0;
        end else begin
            state_q <= state_d;
            quiet_q <= quiet_d;
        end
    end

    // Shared window cycle counter; any exit from RUN/DRAIN drops the partial window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_cnt_q   <= '0;
            win_valid_q <= 1'b0;
        end else begin
            win_valid_q <= wrap;
            if (!active || wrap) win_cnt_q <= '0;
            else                 win_cnt_q <= win_cnt_q + 1'b1;
        end
    end

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        logic [InFlightW-1:0]    rd_cnt, wr_cnt;
        logic [BeatCntWidth-1:0] rd_beats_q, wr_beats_q;
        logic [WinW-1:0]         rd_acc_q, wr_acc_q, win_rd_q, win_wr_q;
        logic                    beat_err_q;

        floo_sat_updown_cnt #(.Max(MaxInFlight), .W(InFlightW)) u_rd_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (clr),
            .en_i   (active),
            .inc_i  (ar_hs_i[c]),
            .dec_i  (r_last_hs_i[c]),
            .cnt_o  (rd_cnt),
            .err_o  (rd_err[c])
        );

        floo_sat_updown_cnt #(.Max(MaxInFlight), .W(InFlightW)) u_wr_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (clr),
            .en_i   (active),
            .inc_i  (aw_hs_i[c]),
            .dec_i  (b_hs_i[c]),
            .cnt_o  (wr_cnt),
            .err_o  (wr_err[c])
        );

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_beats_q <= '0;
                wr_beats_q <= '0;
                rd_acc_q   <= '0;
                wr_acc_q   <= '0;
                win_rd_q   <= '0;
                win_wr_q   <= '0;
                beat_err_q <= 1'b0;
            end else if (clr) begin
                rd_beats_q <= '0;
                wr_beats_q <= '0;
                rd_acc_q   <= '0;
                wr_acc_q   <= '0;
                win_rd_q   <= '0;
                win_wr_q   <= '0;
                beat_err_q <= 1'b0;
            end else if (active) begin
                if (r_hs_i[c] && (rd_beats_q != '1)) rd_beats_q <= rd_beats_q + 1'b1;
                if (w_hs_i[c] && (wr_beats_q != '1)) wr_beats_q <= wr_beats_q + 1'b1;
                if (r_last_hs_i[c] && !r_hs_i[c])    beat_err_q <= 1'b1;
                if (wrap) begin
                    win_rd_q <= rd_acc_q + WinW'(r_hs_i[c]);
                    win_wr_q <= wr_acc_q + WinW'(w_hs_i[c]);
                    rd_acc_q <= '0;
                    wr_acc_q <= '0;
                end else begin
                    rd_acc_q <= rd_acc_q + WinW'(r_hs_i[c]);
                    wr_acc_q <= wr_acc_q + WinW'(w_hs_i[c]);
                end
            end else begin
                rd_acc_q <= '0;
                wr_acc_q <= '0;
            end
        end

        assign rd_nz[c] = |rd_cnt;
        assign wr_nz[c] = |wr_cnt;
        assign err_o[c] = rd_err[c] | wr_err[c] | beat_err_q;

        assign rd_inflight_o[c*InFlightW +: InFlightW]     = rd_cnt;
        assign wr_inflight_o[c*InFlightW +: InFlightW]     = wr_cnt;
        assign rd_beats_o[c*BeatCntWidth +: BeatCntWidth]  = rd_beats_q;
        assign wr_beats_o[c*BeatCntWidth +: BeatCntWidth]  = wr_beats_q;
        assign win_rd_beats_o[c*WinW +: WinW]              = win_rd_q;
        assign win_wr_beats_o[c*WinW +: WinW]              = win_wr_q;
    end

    assign win_valid_o = win_valid_q;
    assign state_o     = state_q;
    assign done_o      = (state_q == StDone);

endmodule

// File: tb/tb_floo_traffic_monitor_mc.sv
// Directed bench for floo_traffic_monitor_mc with small parameters (window 8, drain 4, max 3, 5-bit totals).
module tb_floo_traffic_monitor_mc;

    localparam int NCH = 2;
    localparam int IFW = 2;   // MaxInFlight=3
    localparam int BW  = 5;
    localparam int WW  = 4;   // WindowCycles=8

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic en_i = 1'b0;
    logic [NCH-1:0] eos, ar, aw, rh, wh, rl, bh;
    logic [NCH*IFW-1:0] rd_if, wr_if;
    logic [NCH*BW-1:0]  rd_b, wr_b;
    logic [NCH*WW-1:0]  win_rd, win_wr;
    logic               win_valid, done;
    logic [NCH-1:0]     err;
    logic [1:0]         state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    floo_traffic_monitor_mc #(
        .NumChannels(NCH), .MaxInFlight(3), .BeatCntWidth(BW),
        .WindowCycles(8), .DrainCycles(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .end_of_sim_i(eos),
        .ar_hs_i(ar), .aw_hs_i(aw), .r_hs_i(rh), .w_hs_i(wh),
        .r_last_hs_i(rl), .b_hs_i(bh),
        .rd_inflight_o(rd_if), .wr_inflight_o(wr_if),
        .rd_beats_o(rd_b), .wr_beats_o(wr_b),
        .win_rd_beats_o(win_rd), .win_wr_beats_o(win_wr),
        .win_valid_o(win_valid), .err_o(err), .state_o(state), .done_o(done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hs();
        ar = '0; aw = '0; rh = '0; wh = '0; rl = '0; bh = '0;
    endtask

    task automatic restart();
        clear_hs();
        eos  = '0;
        en_i = 1'b0;
        tick();
        chk("idle_state", 32'(state), 0);
        en_i = 1'b1;
        tick();
        chk("run_state", 32'(state), 1);
    endtask

    initial begin
        clear_hs();
        eos = '0;
        repeat (3) tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rd_if", 32'(rd_if), 0);
        chk("rst_beats", 32'(rd_b), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_winv", 32'(win_valid), 0);
        rst_ni = 1'b1;
        en_i   = 1'b1;
        tick();
        chk("run_entry", 32'(state), 1);

        // three reads on ch0, held, then drained by last beats
        ar = 2'b01;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("rd_if0_up", 32'(rd_if[1:0]), i);
        end
        ar = '0;
        repeat (6) tick();
        chk("rd_if0_hold", 32'(rd_if[1:0]), 3);
        rl = 2'b01; rh = 2'b01;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("rd_if0_dn", 32'(rd_if[1:0]), 3 - i);
        end
        clear_hs();
        tick();
        chk("rd_err_none", 32'(err), 0);

        // increment at MaxInFlight saturates and flags
        restart();
        ar = 2'b01;
        repeat (3) tick();
        chk("sat_if", 32'(rd_if[1:0]), 3);
        chk("sat_err0", 32'(err), 0);
        tick();
        chk("sat_if_hold", 32'(rd_if[1:0]), 3);
        chk("sat_err1", 32'(err), 1);

        // ch1 writes: simultaneous inc/dec, then underflow
        restart();
        aw = 2'b10;
        repeat (2) tick();
        chk("wr_if1_2", 32'(wr_if[3:2]), 2);
        bh = 2'b10;
        tick();
        chk("wr_if1_same", 32'(wr_if[3:2]), 2);
        chk("wr_same_err", 32'(err), 0);
        aw = '0;
        tick();
        chk("wr_if1_1", 32'(wr_if[3:2]), 1);
        tick();
        chk("wr_if1_0", 32'(wr_if[3:2]), 0);
        chk("wr_err_pre", 32'(err), 0);
        tick();
        chk("wr_if1_uf", 32'(wr_if[3:2]), 0);
        chk("wr_err_uf", 32'(err), 2);
        bh = '0;
        repeat (5) tick();
        chk("wr_err_sticky", 32'(err), 2);

        // r_last without an R beat
        restart();
        ar = 2'b01;
        tick();
        ar = '0; rl = 2'b01;
        tick();
        clear_hs();
        chk("lastonly_if", 32'(rd_if[1:0]), 0);
        chk("lastonly_err", 32'(err), 1);

        // window and beat totals
        restart();
        rh = 2'b01;
        for (int k = 1; k <= 40; k++) begin
            wh = (k <= 5) ? 2'b10 : 2'b00;
            tick();
            chk("win_valid", 32'(win_valid), (k % 8 == 0) ? 1 : 0);
            if (k == 8) begin
                chk("win_rd0_w1", 32'(win_rd[3:0]), 8);
                chk("win_wr1_w1", 32'(win_wr[7:4]), 5);
            end
            if (k == 16) begin
                chk("win_rd0_w2", 32'(win_rd[3:0]), 8);
                chk("win_wr1_w2", 32'(win_wr[7:4]), 0);
                chk("rd_beats16", 32'(rd_b[4:0]), 16);
            end
        end
        chk("rd_beats_sat", 32'(rd_b[4:0]), 31);
        chk("wr_beats1", 32'(wr_b[9:5]), 5);
        chk("win_err", 32'(err), 0);
        restart();
        chk("win_cleared", 32'(win_rd[3:0]), 0);

        // drain with one read outstanding, end_of_sim dropping mid-drain
        ar = 2'b01;
        tick();
        ar = '0;
        chk("drn_if", 32'(rd_if[1:0]), 1);
        eos = 2'b11;
        tick();
        chk("drn_state", 32'(state), 2);
        eos = 2'b00;
        repeat (3) tick();
        chk("drn_hold", 32'(state), 2);
        chk("drn_nodone", 32'(done), 0);
        rl = 2'b01; rh = 2'b01;
        tick();
        clear_hs();
        chk("drn_if0", 32'(rd_if[1:0]), 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("drn_done", 32'(done), (i == 4) ? 1 : 0);
        end
        chk("done_state", 32'(state), 3);
        ar = 2'b01; rh = 2'b01;
        tick();
        clear_hs();
        chk("done_frz_if", 32'(rd_if[1:0]), 0);
        chk("done_frz_b", 32'(rd_b[4:0]), 1);
        chk("done_held", 32'(done), 1);

        // new AR restarts the quiet count
        restart();
        eos = 2'b11;
        tick();
        chk("q_state", 32'(state), 2);
        tick();
        tick();
        ar = 2'b10;
        tick();
        ar = '0;
        chk("q_if1", 32'(rd_if[3:2]), 1);
        chk("q_nodone", 32'(done), 0);
        rl = 2'b10; rh = 2'b10;
        tick();
        clear_hs();
        chk("q_nodone2", 32'(done), 0);
        chk("q_if1_0", 32'(rd_if[3:2]), 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("q_done", 32'(done), (i == 4) ? 1 : 0);
        end

        // asynchronous reset out of DONE
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_done", 32'(done), 0);
        chk("arst_state", 32'(state), 0);
        chk("arst_beats", 32'(rd_b), 0);
        #1;
        rst_ni = 1'b1;
        tick();
        chk("arst_run", 32'(state), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/floo_traffic_monitor_mc.md
# floo_traffic_monitor_mc

Synthesizable multi-channel AXI traffic monitor and end-of-simulation controller for FlooNoC compute-tile test nodes. It observes per-channel handshake events from N traffic generators, such as the narrow and wide DMA test nodes of one tile. It tracks outstanding read and write transactions, counts data beats in total and per fixed measurement window, and flags protocol accounting errors. It raises `done_o` only after every channel has reported end-of-simulation and all outstanding traffic has drained.

## Interface
Parameters:
- `NumChannels`, 2: number of monitored AXI channels (≥1).
- `MaxInFlight`, 16: in-flight counter saturation limit per direction per channel.
- `BeatCntWidth`, 32: width of total beat counters.
- `WindowCycles`, 1024: measurement window length in cycles (≥2).
- `DrainCycles`, 64: quiet cycles required after drain before `done_o` (≥1).

Derived:
- `InFlightW = $clog2(MaxInFlight+1)`
- `WinW = $clog2(WindowCycles+1)`

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock; reset is asynchronous and active-low.
- `en_i`  in  1  monitor enable; low forces IDLE and clears state.
- `end_of_sim_i`  in  NumChannels  per-channel generator finished (level).
- `ar_hs_i`, `aw_hs_i`  in  NumChannels  AR/AW valid&ready this cycle.
- `r_hs_i`, `w_hs_i`  in  NumChannels  R/W beat handshake.
- `r_last_hs_i`  in  NumChannels  R handshake with last.
- `b_hs_i`  in  NumChannels  B handshake.
- `rd_inflight_o`, `wr_inflight_o`  out  NumChannels×InFlightW  outstanding reads/writes.
- `rd_beats_o`, `wr_beats_o`  out  NumChannels×BeatCntWidth  total beats since RUN entry.
- `win_rd_beats_o`, `win_wr_beats_o`  out  NumChannels×WinW  beats in last completed window.
- `win_valid_o`  out  1  one-cycle pulse when window outputs update.
- `err_o`  out  NumChannels  sticky accounting error.
- `state_o`  out  2  FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3).
- `done_o`  out  1  simulation complete.

## Operation
FSM:
- **IDLE**: all counters, window accumulators, `err_o` and window outputs are held at 0. Go to RUN when `en_i`=1.
- **RUN**: counting is active. Go to DRAIN when `&end_of_sim_i`=1.
- **DRAIN**: counting continues. The quiet counter increments when all in-flight counters are 0. It resets to 0 whenever any in-flight counter is non-zero. Go to DONE when the quiet counter reaches `DrainCycles-1` while quiet.
- **DONE**: `done_o`=1. All counters and outputs are frozen; handshakes are ignored.
- `en_i`=0 in any state: go to IDLE next cycle and clear everything.

In-flight counters (per channel, per direction):
- Read: `ar_hs_i` increments, `r_last_hs_i` decrements.
- Write: `aw_hs_i` increments, `b_hs_i` decrements.
- Increment and decrement in the same cycle: counter unchanged, no error.
- Decrement at 0: counter stays 0 and `err_o[c]` is set.
- Increment at `MaxInFlight`: counter stays at `MaxInFlight` and `err_o[c]` is set.
- `err_o` is cleared only by reset or IDLE.

Beat counters:
- Totals add 1 per `r_hs_i`/`w_hs_i` and saturate at all-ones; saturation is not an error.
- `r_last_hs_i` without `r_hs_i` in the same cycle is an error.

Window:
- The cycle counter runs in RUN and DRAIN only, from 0 to `WindowCycles-1`, then wraps.
- On the wrap cycle, each window output is loaded with (accumulator + this cycle's beat). The accumulator clears to 0, and `win_valid_o` pulses in the following cycle together with the new values.
- Leaving RUN/DRAIN discards a partial window; no pulse is generated.

## Timing
- All outputs are registered and reflect a handshake one cycle after it (latency 1).
- Reset values: all outputs 0, `state_o`=IDLE.
- An asynchronous reset mid-operation clears everything immediately; `done_o` drops without waiting for a clock.
- The DRAIN→DONE minimum is `DrainCycles` consecutive quiet cycles. `done_o` rises the cycle after the last quiet cycle.
- `end_of_sim_i` dropping during DRAIN does not return the FSM to RUN.

## Structure
- Shared package `floo_test_monitor_pkg` holds the state enum (`monitor_state_e`) and the derived-width helper functions.
- One sub-module, `floo_sat_updown_cnt`, implements a saturating up/down counter with an error flag. Instantiate it 2×NumChannels for the in-flight counters.
- Beat and window logic are generate loops inside the top module.

## Test plan
- Reset, then `en_i`=1, then 3 AR on channel 0 in cycles 1–3 and 3 `r_last_hs` in cycles 10–12 → `rd_inflight_o[0]` shows 1,2,3, holds, then 2,1,0; `err_o`=0.
- Simultaneous `aw_hs_i` and `b_hs_i` on channel 1 with count 2 → stays 2. Then `b_hs_i` three times → reaches 0 and `err_o[1]`=1, which stays set.
- `WindowCycles`=8, `r_hs_i[0]` every cycle → `win_rd_beats_o[0]`=8 and `win_valid_o` pulses every 8 cycles. `rd_beats_o[0]`=16 after the 2nd pulse.
- `end_of_sim_i`=2'b11 with 1 read outstanding, R last 5 cycles later, `DrainCycles`=4 → `state_o`=DRAIN, then `done_o` rises exactly 4 quiet cycles after the in-flight count reaches 0.
- A new AR during the DRAIN quiet count → quiet count restarts; `done_o` is delayed accordingly.
- `rst_ni` asserted while in DONE → `done_o` and all counters go to 0 asynchronously. With `en_i` still high, the FSM reaches RUN one cycle after reset release.
